// File: rtl/apb_mem_pkg.sv
// Shared types and helpers for the APB memory slave.
package apb_mem_pkg;

  typedef enum logic {
    IDLE,
    ACCESS
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_ALIGN,
    ERR_RANGE,
    ERR_RO
  } err_e;

  // Number of byte-offset bits below the word index in a byte address.
  function automatic int unsigned lane_off_w(input int unsigned data_width);
    return (data_width > 8) ? $clog2(data_width / 8) : 0;
  endfunction

endpackage

// File: rtl/apb_mem_array.sv
// Word-organised RAM with per-byte write enables and asynchronous read.
module apb_mem_array #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_DEPTH  = 256,
  parameter int unsigned AW         = 8
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [AW-1:0]           addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] strb,
  output logic [DATA_WIDTH-1:0]   rdata
);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // Byte-lane write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned b = 0; b < DATA_WIDTH / 8; b++) begin
        if (strb[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/apb_mem_slave_p.sv
// APB4 memory slave: access FSM with wait states, byte strobes,
// alignment / range / read-only error checks and a saturating error counter.
module apb_mem_slave_p
  import apb_mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned MEM_DEPTH   = 256,
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned RO_WORDS    = 0
) (
  input  logic                    pclk,
  input  logic                    preset,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pready,
  output logic                    pslverr,
  output logic [7:0]              err_cnt
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned OFFW  = lane_off_w(DATA_WIDTH);
  localparam int unsigned AW    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [3:0]  WS_L  = 4'(WAIT_STATES);

  state_e                  state_q, state_d;
  logic [3:0]              wait_q, wait_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    write_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [BYTES-1:0]        strb_q;
  logic [7:0]              err_cnt_q;

  logic                    latch, complete;
  logic [ADDR_WIDTH-1:0]   idx_full;
  logic                    misaligned, out_of_range, ro_hit;
  err_e                    cause;
  logic                    mem_we;
  logic [DATA_WIDTH-1:0]   rd_data;

  assign idx_full     = addr_q >> OFFW;
  assign misaligned   = (addr_q & ADDR_WIDTH'(BYTES - 1)) != '0;
  assign out_of_range = 32'(idx_full) >= MEM_DEPTH;

  // An empty read-only region must not produce an always-false compare.
  if (RO_WORDS == 0) begin : g_no_ro
    assign ro_hit = 1'b0;
  end else begin : g_ro
    assign ro_hit = 32'(idx_full) < RO_WORDS;
  end

  // State, wait counter, setup-phase latches and error counter.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q   <= IDLE;
      wait_q    <= '0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      strb_q    <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (latch) begin
        addr_q  <= paddr;
        write_q <= pwrite;
        wdata_q <= pwdata;
        strb_q  <= pstrb;
      end
      if (pslverr && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  // Next-state logic: setup latch, wait-state count, abort, completion.
  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    latch    = 1'b0;
    complete = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (psel && !penable) begin
          latch   = 1'b1;
          wait_d  = '0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (!psel) begin
          state_d = IDLE;
        end else if (wait_q != WS_L) begin
          wait_d = wait_q + 4'd1;
        end else if (penable) begin
          complete = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Error classification of the latched transfer, highest priority first.
  always_comb begin
    cause = ERR_NONE;
    if (misaligned)             cause = ERR_ALIGN;
    else if (out_of_range)      cause = ERR_RANGE;
    else if (write_q && ro_hit) cause = ERR_RO;
  end

  // Bus responses are only driven during the completion cycle.
  always_comb begin
    pready  = complete;
    pslverr = complete && (cause != ERR_NONE);
    mem_we  = complete && write_q && (cause == ERR_NONE);
    prdata  = (complete && !write_q && (cause == ERR_NONE)) ? rd_data : '0;
  end

  assign err_cnt = err_cnt_q;

  apb_mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH),
    .AW         (AW)
  ) u_array (
    .clk   (pclk),
    .we    (mem_we),
    .addr  (AW'(idx_full)),
    .wdata (wdata_q),
    .strb  (strb_q),
    .rdata (rd_data)
  );

endmodule
